hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage RV32I core. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB registers around the decode stage.

---
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: load-use stall, redirect flush,
// EX forwarding selects and data-memory freeze with timeout. Optional HAZARD_PERF_CNT_EN adds stall/flush counters.
module hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int REG_AW   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_regwen,
    input  logic              ex_pcsel,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwen,
    input  logic              dmem_busy,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              freeze,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              timeout,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [WCW-1:0] wait_cnt_r;
    logic [WCW-1:0] wait_cnt_nxt_s;
    logic           load_use_s;

    // x0 is hardwired zero, so it is never a forwarding source
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              m_wen,
        input logic [REG_AW-1:0] m_rd,
        input logic              w_wen,
        input logic [REG_AW-1:0] w_rd
    );
        logic [1:0] sel;
        if (m_wen && (m_rd != {REG_AW{1'b0}}) && (m_rd == src)) begin
            sel = 2'b01;
        end else if (w_wen && (w_rd != {REG_AW{1'b0}}) && (w_rd == src)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Load-use detect, next state, wait counter and pipeline control outputs
    always_comb begin
        load_use_s = ex_is_load && ex_regwen && (ex_rd != {REG_AW{1'b0}}) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
        state_nxt_s    = dmem_busy ? WAIT : RUN;
        wait_cnt_nxt_s = {WCW{1'b0}};
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        freeze         = 1'b0;
        fwd_a_sel      = fwd_sel(ex_rs1, mem_regwen, mem_rd, wb_regwen, wb_rd);
        fwd_b_sel      = fwd_sel(ex_rs2, mem_regwen, mem_rd, wb_regwen, wb_rd);

        // The first busy cycle is seen in RUN, so it counts as one wait cycle
        if (dmem_busy) begin
            if (state_r == WAIT) begin
                wait_cnt_nxt_s = (wait_cnt_r == WAIT_MAX) ? wait_cnt_r : wait_cnt_r + {{(WCW-1){1'b0}}, 1'b1};
            end else begin
                wait_cnt_nxt_s = {{(WCW-1){1'b0}}, 1'b1};
            end
        end else begin
            wait_cnt_nxt_s = {WCW{1'b0}};
        end

        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            freeze      = 1'b0;
            fwd_a_sel   = 2'b00;
            fwd_b_sel   = 2'b00;
        end else if (dmem_busy) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            freeze  = 1'b1;
        end else if (ex_pcsel) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use_s) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            pc_en = 1'b1;
        end
    end

    // State, wait counter and sticky timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= RUN;
            wait_cnt_r <= {WCW{1'b0}};
            timeout    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            if (dmem_busy && (wait_cnt_r == WAIT_MAX)) begin
                timeout <= 1'b1;
            end else begin
                timeout <= timeout;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Performance counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (dmem_busy || (!ex_pcsel && load_use_s)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (!dmem_busy && ex_pcsel) begin
                flush_cnt <= flush_cnt + 32'd1;
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized self-checking bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int MAX_WAIT = 16;
    localparam int REG_AW   = 5;

    logic clk = 1'b0;
    logic reset;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_is_load, ex_regwen, ex_pcsel;
    logic mem_regwen, wb_regwen, dmem_busy;
    logic pc_en, ifid_en, ifid_flush, idex_bubble, freeze, timeout;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    int          m_run;
    bit          m_timeout;
    logic [31:0] m_stall, m_flush;

    hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .REG_AW(REG_AW)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_regwen(ex_regwen), .ex_pcsel(ex_pcsel),
        .mem_rd(mem_rd), .mem_regwen(mem_regwen), .wb_rd(wb_rd), .wb_regwen(wb_regwen),
        .dmem_busy(dmem_busy),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .freeze(freeze), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .timeout(timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        reset = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_is_load = 1'b0; ex_regwen = 1'b0;
        ex_pcsel = 1'b0; mem_rd = '0; mem_regwen = 1'b0; wb_rd = '0; wb_regwen = 1'b0;
        dmem_busy = 1'b0;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] src);
        if (mem_regwen && mem_rd != 0 && mem_rd == src) return 2'b01;
        if (wb_regwen && wb_rd != 0 && wb_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    // One clock: inputs already applied; check outputs before the edge, state after it
    task automatic step();
        bit lu;
        bit e_pc, e_ifen, e_fl, e_bub, e_frz;
        logic [1:0] e_fa, e_fb;
        logic [31:0] e_stall, e_flush;
        #4;
        lu = ex_is_load && ex_regwen && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        e_fa = ref_fwd(ex_rs1);
        e_fb = ref_fwd(ex_rs2);
        e_frz = 1'b0; e_fl = 1'b0; e_bub = 1'b0; e_pc = 1'b1; e_ifen = 1'b1;
        if (reset) begin
            e_pc = 1'b0; e_ifen = 1'b0; e_fl = 1'b1; e_bub = 1'b1; e_fa = 2'b00; e_fb = 2'b00;
        end else if (dmem_busy) begin
            e_pc = 1'b0; e_ifen = 1'b0; e_frz = 1'b1;
        end else if (ex_pcsel) begin
            e_fl = 1'b1; e_bub = 1'b1;
        end else if (lu) begin
            e_pc = 1'b0; e_ifen = 1'b0; e_bub = 1'b1;
        end
        check("pc_en", 32'(pc_en), 32'(e_pc));
        check("ifid_en", 32'(ifid_en), 32'(e_ifen));
        check("ifid_flush", 32'(ifid_flush), 32'(e_fl));
        check("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        check("freeze", 32'(freeze), 32'(e_frz));
        check("fwd_a_sel", 32'(fwd_a_sel), 32'(e_fa));
        check("fwd_b_sel", 32'(fwd_b_sel), 32'(e_fb));
        @(posedge clk);
        if (reset) begin
            m_run = 0; m_timeout = 1'b0; m_stall = 32'd0; m_flush = 32'd0;
        end else begin
            if (dmem_busy && m_run >= MAX_WAIT) m_timeout = 1'b1;
            m_run = dmem_busy ? m_run + 1 : 0;
            if (dmem_busy || (!ex_pcsel && lu)) m_stall = m_stall + 32'd1;
            if (!dmem_busy && ex_pcsel) m_flush = m_flush + 32'd1;
        end
`ifdef HAZARD_PERF_CNT_EN
        e_stall = m_stall; e_flush = m_flush;
`else
        e_stall = 32'd0; e_flush = 32'd0;
`endif
        #1;
        check("timeout", 32'(timeout), 32'(m_timeout));
        check("stall_cnt", stall_cnt, e_stall);
        check("flush_cnt", flush_cnt, e_flush);
        @(negedge clk);
    endtask

    task automatic randomize_inputs();
        id_rs1 = REG_AW'($urandom_range(0, 3)); id_rs2 = REG_AW'($urandom_range(0, 3));
        ex_rs1 = REG_AW'($urandom_range(0, 3)); ex_rs2 = REG_AW'($urandom_range(0, 3));
        ex_rd  = REG_AW'($urandom_range(0, 3)); mem_rd = REG_AW'($urandom_range(0, 3));
        wb_rd  = REG_AW'($urandom_range(0, 3));
        id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
        ex_is_load = 1'($urandom); ex_regwen = 1'($urandom);
        mem_regwen = 1'($urandom); wb_regwen = 1'($urandom);
        ex_pcsel = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        int busy_left;
        m_run = 0; m_timeout = 1'b0; m_stall = 32'd0; m_flush = 32'd0;
        clear_inputs();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        // load-use on rs1, then the bubble clears the match
        ex_is_load = 1'b1; ex_regwen = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        step();
        clear_inputs();
        step();
        ex_is_load = 1'b1; ex_regwen = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        step();

        // forwarding priority
        clear_inputs();
        mem_rd = 5'd7; wb_rd = 5'd7; mem_regwen = 1'b1; wb_regwen = 1'b1;
        ex_rs1 = 5'd7; ex_rs2 = 5'd7;
        step();
        mem_regwen = 1'b0;
        step();

        // redirect overrides load-use
        clear_inputs();
        ex_pcsel = 1'b1; ex_is_load = 1'b1; ex_regwen = 1'b1; ex_rd = 5'd5;
        id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        step();

        // short and long memory waits
        clear_inputs();
        dmem_busy = 1'b1;
        repeat (4) step();
        dmem_busy = 1'b0;
        step();
        dmem_busy = 1'b1;
        repeat (20) step();
        dmem_busy = 1'b0;
        repeat (2) step();

        // wait with pending redirect
        dmem_busy = 1'b1; ex_pcsel = 1'b1;
        repeat (2) step();
        dmem_busy = 1'b0;
        step();

        // reset clears sticky timeout, then random traffic
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        busy_left = 0;
        for (int i = 0; i < 1500; i++) begin
            randomize_inputs();
            if (busy_left == 0 && $urandom_range(0, 19) == 0) busy_left = $urandom_range(1, 22);
            dmem_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            reset = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
